// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: address/data words, FIFO entry layout, flush FSM states.
// No logic here; widths are fixed at 32-bit physical addresses and 32-bit data words.
// SB_DEPTH is the default FIFO depth used by store_buffer and its forwarding scan.
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int PPTR_W   = 32;
   localparam int WORD_W   = 32;

   typedef logic [PPTR_W-1:0] pptr_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic  isbyte;
      pptr_t addr;
      word_t data;
   } sb_entry_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } sb_state_t;

endpackage

// File: rtl/store_buffer_sb_forward.sv
// Store-to-load forwarding: youngest-first scan of held stores for a word-address match.
// Latency: purely combinational, result valid in the same cycle as the probe.
// Backpressure: none; a conflict tells the load stage to replay rather than stall here.
module store_buffer_sb_forward
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] i_entries,
   input  logic [DEPTH-1:0]      i_vld,
   input  logic [PTR_W-1:0]      i_wr_ptr,
   input  logic                  i_lookup_en,
   input  pptr_t                 i_lookup_addr,
   input  logic                  i_lookup_isbyte,
   output logic                  o_hit,
   output logic                  o_conflict,
   output word_t                 o_data
);

   logic             w_found;
   logic [PTR_W-1:0] w_idx;
   sb_entry_t        w_ent;
   logic [7:0]       w_byte_sel;

   // Walk from the slot just behind wr_ptr (youngest) back to wr_ptr itself (oldest); first match wins.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_ent   = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         w_idx = i_wr_ptr - PTR_W'(i);
         if (!w_found && i_vld[w_idx] &&
             (i_entries[w_idx].addr[PPTR_W-1:2] == i_lookup_addr[PPTR_W-1:2])) begin
            w_found = 1'b1;
            w_ent   = i_entries[w_idx];
         end
      end
   end

   // Little-endian byte pick out of a matching word store.
   always_comb begin
      case (i_lookup_addr[1:0])
         2'd0:    w_byte_sel = w_ent.data[7:0];
         2'd1:    w_byte_sel = w_ent.data[15:8];
         2'd2:    w_byte_sel = w_ent.data[23:16];
         default: w_byte_sel = w_ent.data[31:24];
      endcase
   end

   // Decide hit / conflict from the youngest matching store only.
   always_comb begin
      o_hit      = 1'b0;
      o_conflict = 1'b0;
      o_data     = '0;
      if (i_lookup_en && w_found) begin
         if (!w_ent.isbyte) begin
            o_hit  = 1'b1;
            o_data = i_lookup_isbyte ? {24'b0, w_byte_sel} : w_ent.data;
         end else if (i_lookup_isbyte && (w_ent.addr[1:0] == i_lookup_addr[1:0])) begin
            o_hit  = 1'b1;
            o_data = {24'b0, w_ent.data[7:0]};
         end else begin
            // Partial overlap with a byte store: the load cannot be assembled here.
            o_conflict = 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining in order to the d-cache, with load forwarding and a flush fence.
// Latency: a pushed store is offered on drain_* the cycle after the push; lookups are same-cycle.
// Backpressure: full stalls TL stores (a push at full is accepted only alongside a pop); drain holds until ack.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  store_en,
   input  logic  store_isbyte,
   input  pptr_t store_addr,
   input  word_t store_data,
   output logic  full,
   output logic  empty,
   output logic  drain_valid,
   output logic  drain_isbyte,
   output pptr_t drain_addr,
   output word_t drain_data,
   input  logic  drain_ack,
   input  logic  lookup_en,
   input  pptr_t lookup_addr,
   input  logic  lookup_isbyte,
   output logic  lookup_hit,
   output word_t lookup_data,
   output logic  lookup_conflict,
   input  logic  flush_req,
   output logic  flush_done,
   output logic  overflow
);

   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);

   sb_entry_t [DEPTH-1:0] r_mem;
   logic [DEPTH-1:0]      r_vld;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;
   sb_state_t             r_state;

   sb_state_t             w_state_nxt;
   logic                  w_flush_done;
   logic                  w_pop;
   logic                  w_push;
   logic [PTR_W:0]        w_count_nxt;

   // A pop frees a slot in the same cycle, so a push at full is still accepted when paired with an ack.
   assign w_pop       = !r_empty && drain_ack;
   assign w_push      = store_en && (!r_full || w_pop);
   assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

   // FIFO storage, pointers, occupancy flags and the sticky overflow error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem      <= '0;
         r_vld      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + PTR_ONE;
         end
         // Placed after the pop so a push into the slot being freed leaves it valid.
         if (w_push) begin
            r_mem[r_wr_ptr] <= '{isbyte: store_isbyte, addr: store_addr, data: store_data};
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (store_en && !w_push) begin
            r_overflow <= 1'b1;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_FULL);
         r_empty <= (w_count_nxt == '0);
      end
   end

   // Flush FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Flush sequencing: done fires in the cycle the buffer becomes empty, including the last pop.
   always_comb begin
      w_state_nxt  = r_state;
      w_flush_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (flush_req) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (w_count_nxt == '0) begin
               w_flush_done = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign full         = r_full;
   assign empty        = r_empty;
   assign overflow     = r_overflow;
   assign flush_done   = w_flush_done;
   assign drain_valid  = !r_empty;
   assign drain_isbyte = r_mem[r_rd_ptr].isbyte;
   assign drain_addr   = r_mem[r_rd_ptr].addr;
   assign drain_data   = r_mem[r_rd_ptr].data;

   store_buffer_sb_forward #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_forward (
      .i_entries       (r_mem),
      .i_vld           (r_vld),
      .i_wr_ptr        (r_wr_ptr),
      .i_lookup_en     (lookup_en),
      .i_lookup_addr   (lookup_addr),
      .i_lookup_isbyte (lookup_isbyte),
      .o_hit           (lookup_hit),
      .o_conflict      (lookup_conflict),
      .o_data          (lookup_data)
   );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by a randomized run against a queue model.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1ns after it.
// The model tracks contents as an ordered list of stores and derives forwarding from that list.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  store_en, store_isbyte;
   pptr_t store_addr;
   word_t store_data;
   logic  full, empty, drain_valid, drain_isbyte;
   pptr_t drain_addr;
   word_t drain_data;
   logic  drain_ack, lookup_en, lookup_isbyte;
   pptr_t lookup_addr;
   logic  lookup_hit, lookup_conflict;
   word_t lookup_data;
   logic  flush_req, flush_done, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        isbyte;
      logic [31:0] addr;
      logic [31:0] data;
   } mentry_t;

   mentry_t q[$];
   logic    m_ovf;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk             (clk),
      .rst             (rst),
      .store_en        (store_en),
      .store_isbyte    (store_isbyte),
      .store_addr      (store_addr),
      .store_data      (store_data),
      .full            (full),
      .empty           (empty),
      .drain_valid     (drain_valid),
      .drain_isbyte    (drain_isbyte),
      .drain_addr      (drain_addr),
      .drain_data      (drain_data),
      .drain_ack       (drain_ack),
      .lookup_en       (lookup_en),
      .lookup_addr     (lookup_addr),
      .lookup_isbyte   (lookup_isbyte),
      .lookup_hit      (lookup_hit),
      .lookup_data     (lookup_data),
      .lookup_conflict (lookup_conflict),
      .flush_req       (flush_req),
      .flush_done      (flush_done),
      .overflow        (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic idle();
      store_en     = 1'b0;
      store_isbyte = 1'b0;
      drain_ack    = 1'b0;
      lookup_en    = 1'b0;
      flush_req    = 1'b0;
   endtask

   task automatic set_store(input logic isb, input logic [31:0] a, input logic [31:0] d);
      store_en     = 1'b1;
      store_isbyte = isb;
      store_addr   = a;
      store_data   = d;
   endtask

   // Forwarding result derived from the ordered store list: newest store on the same word decides.
   function automatic void model_fwd(input logic en, input logic isb, input logic [31:0] a,
                                     output logic hit, output logic conf, output logic [31:0] d);
      hit  = 1'b0;
      conf = 1'b0;
      d    = '0;
      if (!en) return;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].addr[31:2] == a[31:2]) begin
            if (!q[i].isbyte) begin
               hit = 1'b1;
               d   = isb ? ((q[i].data >> (8 * a[1:0])) & 32'hFF) : q[i].data;
            end else if (isb && (q[i].addr[1:0] == a[1:0])) begin
               hit = 1'b1;
               d   = q[i].data & 32'hFF;
            end else begin
               conf = 1'b1;
            end
            return;
         end
      end
   endfunction

   initial begin
      logic        e_hit, e_conf, pop, acc;
      logic [31:0] e_data, base;

      rst = 1'b1;
      idle();
      store_addr    = '0;
      store_data    = '0;
      lookup_addr   = '0;
      lookup_isbyte = 1'b0;

      // Reset values
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_drain_valid", drain_valid, 0);
      chk("rst_hit", lookup_hit, 0);
      chk("rst_conflict", lookup_conflict, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_overflow", overflow, 0);
      nxt();
      rst = 1'b0;

      // Reset while a drain is being offered
      set_store(1'b0, 32'h10, 32'hCAFE0010);
      nxt();
      set_store(1'b0, 32'h14, 32'hCAFE0014);
      nxt();
      idle();
      chk("t1_valid_before", drain_valid, 1);
      chk("t1_addr_before", drain_addr, 32'h10);
      rst = 1'b1;
      #1;
      chk("t1_empty_after", empty, 1);
      chk("t1_valid_after", drain_valid, 0);
      nxt();
      rst = 1'b0;

      // Fill to full, then one dropped push
      for (int k = 0; k < 5; k++) begin
         set_store(1'b0, 32'h100 + 32'(4 * k), 32'hD0000100 + 32'(4 * k));
         nxt();
         if (k == 3) begin
            chk("t2_full_4th", full, 1);
            chk("t2_ovf_4th", overflow, 0);
         end
      end
      idle();
      chk("t2_full_5th", full, 1);
      chk("t2_ovf_5th", overflow, 1);
      for (int k = 0; k < 4; k++) begin
         chk("t2_drain_valid", drain_valid, 1);
         chk("t2_drain_addr", drain_addr, 32'h100 + 32'(4 * k));
         chk("t2_drain_data", drain_data, 32'hD0000100 + 32'(4 * k));
         drain_ack = 1'b1;
         nxt();
      end
      idle();
      chk("t2_empty", empty, 1);
      chk("t2_ovf_sticky", overflow, 1);

      // Push and pop together while full
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_store(1'b0, 32'h100 + 32'(4 * k), 32'(k));
         nxt();
      end
      set_store(1'b0, 32'h200, 32'h200);
      drain_ack = 1'b1;
      #1;
      chk("t3_head_at_pop", drain_addr, 32'h100);
      nxt();
      idle();
      chk("t3_full", full, 1);
      chk("t3_no_ovf", overflow, 0);
      for (int k = 0; k < 4; k++) begin
         chk("t3_order", drain_addr, (k == 3) ? 32'h200 : 32'h104 + 32'(4 * k));
         drain_ack = 1'b1;
         nxt();
      end
      idle();
      chk("t3_empty", empty, 1);

      // Forwarding against a word store shadowed by a byte store
      set_store(1'b0, 32'h300, 32'hAABBCCDD);
      nxt();
      set_store(1'b1, 32'h302, 32'h12345611);
      nxt();
      idle();
      lookup_en     = 1'b1;
      lookup_isbyte = 1'b1;
      lookup_addr   = 32'h302;
      #1;
      chk("t4_b302_hit", lookup_hit, 1);
      chk("t4_b302_data", lookup_data, 32'h11);
      chk("t4_b302_conf", lookup_conflict, 0);
      lookup_isbyte = 1'b0;
      lookup_addr   = 32'h300;
      #1;
      chk("t4_w300_conf", lookup_conflict, 1);
      chk("t4_w300_hit", lookup_hit, 0);
      lookup_isbyte = 1'b1;
      lookup_addr   = 32'h301;
      #1;
      chk("t4_b301_conf", lookup_conflict, 1);
      chk("t4_b301_hit", lookup_hit, 0);
      lookup_addr   = 32'h304;
      #1;
      chk("t4_nomatch_hit", lookup_hit, 0);
      chk("t4_nomatch_conf", lookup_conflict, 0);
      nxt();
      idle();
      drain_ack = 1'b1;
      nxt();
      chk("t4_byte_payload", drain_data, 32'h12345611);
      chk("t4_byte_flag", drain_isbyte, 1);
      nxt();
      idle();

      // Pointer wrap with one entry at a time
      for (int k = 0; k < 10; k++) begin
         set_store(1'b0, 32'h500 + 32'(4 * k), 32'h5000 + 32'(k));
         nxt();
         store_en = 1'b0;
         chk("t5_wrap_addr", drain_addr, 32'h500 + 32'(4 * k));
         drain_ack = 1'b1;
         nxt();
         drain_ack = 1'b0;
      end
      chk("t5_empty", empty, 1);

      // Flush with three entries, acks spaced by an idle cycle
      for (int k = 0; k < 3; k++) begin
         set_store(1'b0, 32'h600 + 32'(4 * k), 32'(k));
         nxt();
      end
      idle();
      flush_req = 1'b1;
      #1;
      chk("t6_done_at_req", flush_done, 0);
      nxt();
      flush_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drain_ack = 1'b1;
         #1;
         chk("t6_done_on_ack", flush_done, (k == 2) ? 1 : 0);
         nxt();
         drain_ack = 1'b0;
         #1;
         chk("t6_done_gap", flush_done, 0);
         nxt();
      end
      flush_req = 1'b1;
      #1;
      chk("t6_empty_req", flush_done, 0);
      nxt();
      flush_req = 1'b0;
      #1;
      chk("t6_empty_pulse", flush_done, 1);
      nxt();
      #1;
      chk("t6_empty_after", flush_done, 0);

      // Randomized traffic on a small address window against the queue model
      rst = 1'b1;
      #1;
      rst = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      nxt();
      for (int c = 0; c < 400; c++) begin
         chk("r_full", full, (q.size() == 4) ? 1 : 0);
         chk("r_empty", empty, (q.size() == 0) ? 1 : 0);
         chk("r_valid", drain_valid, (q.size() != 0) ? 1 : 0);
         chk("r_ovf", overflow, m_ovf);
         if (q.size() != 0) begin
            chk("r_daddr", drain_addr, q[0].addr);
            chk("r_ddata", drain_data, q[0].data);
            chk("r_disb", drain_isbyte, q[0].isbyte);
         end
         store_en     = ($urandom_range(0, 99) < 55);
         store_isbyte = $urandom_range(0, 1) == 1;
         base         = 32'h700 + 32'(4 * $urandom_range(0, 3));
         store_addr   = store_isbyte ? base + 32'($urandom_range(0, 3)) : base;
         store_data   = $urandom;
         drain_ack    = ($urandom_range(0, 99) < 45);
         lookup_en    = ($urandom_range(0, 99) < 70);
         lookup_isbyte = $urandom_range(0, 1) == 1;
         base         = 32'h700 + 32'(4 * $urandom_range(0, 3));
         lookup_addr  = lookup_isbyte ? base + 32'($urandom_range(0, 3)) : base;
         flush_req    = 1'b0;
         #1;
         model_fwd(lookup_en, lookup_isbyte, lookup_addr, e_hit, e_conf, e_data);
         chk("r_hit", lookup_hit, e_hit);
         chk("r_conf", lookup_conflict, e_conf);
         if (e_hit) chk("r_fdata", lookup_data, e_data);
         chk("r_flush_done", flush_done, 0);
         pop = drain_ack && (q.size() != 0);
         acc = store_en && ((q.size() < 4) || pop);
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{isbyte: store_isbyte, addr: store_addr, data: store_data});
         else if (store_en) m_ovf = 1'b1;
         nxt();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
